// File: rtl/color_manager_cmd_decoder.sv
// ---------------------------------------------------------------------------
// color_manager_cmd_decoder
//
// Decodes 5-byte UART command frames (START, ADDR, DATA_HI, DATA_LO, CHK with
// CHK = ADDR ^ DATA_HI ^ DATA_LO) into single-cycle configuration-bus writes.
// Aborted frames (bad address, bad checksum, inter-byte timeout) pulse
// Frame_Error; bytes arriving while a write is pending pulse Overrun. Both
// events feed a saturating error counter.
//
// Ports
//   Clk          : clock, all state on rising edge
//   Rst          : asynchronous active-high reset
//   Rx_Data[7:0] : received byte, qualified by Rx_Valid
//   Rx_Valid     : one-cycle byte strobe
//   C_Rdy        : consumer ready
//   C_Addr       : configuration address (holds last issued value)
//   C_Data       : configuration data    (holds last issued value)
//   C_Valid      : one-cycle write strobe
//   Frame_Error  : one-cycle pulse per aborted frame
//   Overrun      : one-cycle pulse per byte dropped while a write is pending
//   Err_Count    : saturating count of Frame_Error + Overrun events
// ---------------------------------------------------------------------------
module color_manager_cmd_decoder #(
  parameter int         C_ADDR_WIDTH   = 4,
  parameter int         C_DATA_WIDTH   = 16,
  parameter logic [7:0] START_BYTE     = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter int         ERR_CNT_WIDTH  = 8
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [7:0]               Rx_Data,
  input  logic                     Rx_Valid,
  input  logic                     C_Rdy,
  output logic [C_ADDR_WIDTH-1:0]  C_Addr,
  output logic [C_DATA_WIDTH-1:0]  C_Data,
  output logic                     C_Valid,
  output logic                     Frame_Error,
  output logic                     Overrun,
  output logic [ERR_CNT_WIDTH-1:0] Err_Count
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_DHI   = 3'd2;
  localparam logic [2:0] S_DLO   = 3'd3;
  localparam logic [2:0] S_CHK   = 3'd4;
  localparam logic [2:0] S_ISSUE = 3'd5;

  // {DATA_HI, DATA_LO} truncated or zero-extended to the bus width.
  function automatic logic [C_DATA_WIDTH-1:0] pack_data(input logic [7:0] hi,
                                                        input logic [7:0] lo);
    logic [C_DATA_WIDTH+15:0] ext;
    ext = {{C_DATA_WIDTH{1'b0}}, hi, lo};
    return ext[C_DATA_WIDTH-1:0];
  endfunction

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [2:0]               state_q, state_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic                     c_valid_q, c_valid_d;
  logic                     frame_err_q, frame_err_d;
  logic                     overrun_q, overrun_d;
  logic [C_ADDR_WIDTH-1:0]  c_addr_q, c_addr_d;
  logic [C_DATA_WIDTH-1:0]  c_data_q, c_data_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [C_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [7:0]               dhi_q, dhi_d;
  logic [7:0]               dlo_q, dlo_d;

  logic       in_frame;
  logic       timeout;
  logic [7:0] addr_hi_bits;
  logic [7:0] chk_calc;

  assign in_frame     = (state_q == S_ADDR) || (state_q == S_DHI) ||
                        (state_q == S_DLO)  || (state_q == S_CHK);
  // Any Rx_Valid restarts the gap measurement, so a byte can never time out.
  assign timeout      = in_frame && !Rx_Valid && (tmo_q == TMO_LAST);
  assign addr_hi_bits = Rx_Data >> C_ADDR_WIDTH;
  // Stored address has its upper bits known to be zero once accepted.
  assign chk_calc     = 8'(addr_q) ^ dhi_q ^ dlo_q;

  // decode stage
  always_comb begin
    state_d     = state_q;
    c_valid_d   = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    c_addr_d    = c_addr_q;
    c_data_d    = c_data_q;
    addr_d      = addr_q;
    dhi_d       = dhi_q;
    dlo_d       = dlo_q;
    tmo_d       = (in_frame && !Rx_Valid && !timeout) ? tmo_q + 1'b1 : '0;

    case (state_q)
      S_IDLE: begin
        if (Rx_Valid && (Rx_Data == START_BYTE)) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (Rx_Valid) begin
          if (addr_hi_bits != 8'd0) begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            addr_d  = Rx_Data[C_ADDR_WIDTH-1:0];
            state_d = S_DHI;
          end
        end
      end
      S_DHI: begin
        if (Rx_Valid) begin
          dhi_d   = Rx_Data;
          state_d = S_DLO;
        end
      end
      S_DLO: begin
        if (Rx_Valid) begin
          dlo_d   = Rx_Data;
          state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (Rx_Valid) begin
          if (Rx_Data == chk_calc) begin
            state_d = S_ISSUE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
      end
      S_ISSUE: begin
        // The C_Valid cycle still belongs to ISSUE, so bytes there are dropped too.
        overrun_d = Rx_Valid;
        if (c_valid_q) begin
          state_d = S_IDLE;
        end else if (C_Rdy) begin
          c_valid_d = 1'b1;
          c_addr_d  = addr_q;
          c_data_d  = pack_data(dhi_q, dlo_q);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout) begin
      frame_err_d = 1'b1;
      state_d     = S_IDLE;
    end

    // Frame_Error and Overrun are exclusive by state, so at most +1 per cycle.
    err_cnt_d = (frame_err_d || overrun_d) ? sat_inc(err_cnt_q) : err_cnt_q;
  end

  // register stage
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      tmo_q       <= '0;
      c_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      c_addr_q    <= '0;
      c_data_q    <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      c_valid_q   <= c_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      c_addr_q    <= c_addr_d;
      c_data_q    <= c_data_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Frame byte holding registers need no reset: they are only read after
  // being written by the frame that is issuing.
  always_ff @(posedge Clk) begin
    addr_q <= addr_d;
    dhi_q  <= dhi_d;
    dlo_q  <= dlo_d;
  end

  assign C_Addr      = c_addr_q;
  assign C_Data      = c_data_q;
  assign C_Valid     = c_valid_q;
  assign Frame_Error = frame_err_q;
  assign Overrun     = overrun_q;
  assign Err_Count   = err_cnt_q;

endmodule

// File: tb/tb_color_manager_cmd_decoder.sv
module tb_color_manager_cmd_decoder;

  localparam int AW  = 4;
  localparam int DW  = 16;
  localparam int EW  = 8;
  localparam int TMO = 16;

  logic          Clk;
  logic          Rst;
  logic [7:0]    Rx_Data;
  logic          Rx_Valid;
  logic          C_Rdy;
  logic [AW-1:0] C_Addr;
  logic [DW-1:0] C_Data;
  logic          C_Valid;
  logic          Frame_Error;
  logic          Overrun;
  logic [EW-1:0] Err_Count;

  color_manager_cmd_decoder #(
    .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .START_BYTE(8'hA5),
    .TIMEOUT_CYCLES(TMO), .ERR_CNT_WIDTH(EW)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Rx_Data(Rx_Data), .Rx_Valid(Rx_Valid), .C_Rdy(C_Rdy),
    .C_Addr(C_Addr), .C_Data(C_Data), .C_Valid(C_Valid),
    .Frame_Error(Frame_Error), .Overrun(Overrun), .Err_Count(Err_Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_checks, n_fail;
  int cv_cnt, fe_cnt, ov_cnt, last_cv_cyc, last_fe_cyc;
  bit prev_cv;
  logic [AW+DW-1:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes a write.
  task automatic monitor_loop();
    logic [AW+DW-1:0] e;
    forever begin
      @(negedge Clk);
      if (!Rst) begin
        if (C_Valid) begin
          cv_cnt++;
          last_cv_cyc = cyc;
          chk("cv_single_cycle", 32'(prev_cv), 0);
          chk("cv_expected", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("c_addr", 32'(C_Addr), 32'(e[AW+DW-1:DW]));
            chk("c_data", 32'(C_Data), 32'(e[DW-1:0]));
          end
        end
        if (Frame_Error || Overrun) chk("fe_ov_exclusive", 32'(Frame_Error & Overrun), 0);
        if (Frame_Error) begin
          fe_cnt++;
          last_fe_cyc = cyc;
        end
        if (Overrun) ov_cnt++;
      end
      prev_cv = C_Valid;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge Clk); #1;
    Rx_Data  = b;
    Rx_Valid = 1'b1;
    @(posedge Clk); #1;
    Rx_Valid = 1'b0;
  endtask

  task automatic send5(input logic [7:0] b0, b1, b2, b3, b4);
    send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3); send_byte(b4);
  endtask

  task automatic do_reset(input bit check_outputs);
    @(posedge Clk); #1;
    Rst = 1'b1;
    Rx_Valid = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    if (check_outputs) begin
      chk("rst_c_valid", 32'(C_Valid), 0);
      chk("rst_frame_error", 32'(Frame_Error), 0);
      chk("rst_overrun", 32'(Overrun), 0);
      chk("rst_c_addr", 32'(C_Addr), 0);
      chk("rst_c_data", 32'(C_Data), 0);
      chk("rst_err_count", 32'(Err_Count), 0);
    end
    @(posedge Clk); #1;
    Rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(posedge Clk);
    end
    chk("sb_drained", 32'(sb.size()), 0);
    repeat (2) @(posedge Clk);
  endtask

  int base_cv, base_fe, base_ov, t0, chk_cyc;

  initial begin
    n_checks = 0; n_fail = 0;
    cv_cnt = 0; fe_cnt = 0; ov_cnt = 0; last_cv_cyc = 0; last_fe_cyc = 0; prev_cv = 0;
    Rst = 1'b1; Rx_Data = 8'h00; Rx_Valid = 1'b0; C_Rdy = 1'b1;
    fork monitor_loop(); join_none

    // Reset values
    do_reset(1'b1);

    // Basic valid frame, latency 1 after the CHK byte
    base_cv = cv_cnt;
    sb.push_back({4'h1, 16'h1234});
    send5(8'hA5, 8'h01, 8'h12, 8'h34, 8'h27);
    chk_cyc = cyc;
    drain();
    chk("basic_cv_count", 32'(cv_cnt - base_cv), 1);
    chk("basic_latency", 32'(last_cv_cyc - chk_cyc), 1);
    chk("basic_err_count", 32'(Err_Count), 0);
    repeat (5) @(posedge Clk);
    @(negedge Clk);
    chk("hold_c_addr", 32'(C_Addr), 32'h1);
    chk("hold_c_data", 32'(C_Data), 32'h1234);

    // Checksum error, then a valid frame is accepted
    do_reset(1'b0);
    base_cv = cv_cnt; base_fe = fe_cnt;
    send5(8'hA5, 8'h01, 8'h12, 8'h34, 8'h00);
    repeat (4) @(posedge Clk);
    chk("cksum_fe", 32'(fe_cnt - base_fe), 1);
    chk("cksum_no_cv", 32'(cv_cnt - base_cv), 0);
    chk("cksum_err_count", 32'(Err_Count), 1);
    sb.push_back({4'h3, 16'hABCD});
    send5(8'hA5, 8'h03, 8'hAB, 8'hCD, 8'h65);
    drain();
    chk("cksum_next_cv", 32'(cv_cnt - base_cv), 1);

    // Consumer not ready for 10 cycles, one byte overruns
    do_reset(1'b0);
    base_cv = cv_cnt; base_ov = ov_cnt;
    C_Rdy = 1'b0;
    sb.push_back({4'h2, 16'h55AA});
    send5(8'hA5, 8'h02, 8'h55, 8'hAA, 8'hFD);
    repeat (3) @(posedge Clk);
    send_byte(8'h55);
    repeat (5) @(posedge Clk);
    #1;
    chk("wait_no_cv", 32'(cv_cnt - base_cv), 0);
    chk("wait_overrun", 32'(ov_cnt - base_ov), 1);
    C_Rdy = 1'b1;
    drain();
    chk("wait_cv_count", 32'(cv_cnt - base_cv), 1);
    chk("wait_err_count", 32'(Err_Count), 1);

    // Inter-byte timeout
    do_reset(1'b0);
    base_fe = fe_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    t0 = cyc;
    for (int i = 0; i < 40; i++) begin
      if (fe_cnt != base_fe) break;
      @(posedge Clk);
    end
    chk("tmo_fired", 32'(fe_cnt - base_fe), 1);
    chk("tmo_cycle", 32'(last_fe_cyc - t0), TMO);
    chk("tmo_err_count", 32'(Err_Count), 1);
    repeat (40) @(posedge Clk);
    chk("idle_no_tmo", 32'(fe_cnt - base_fe), 1);
    base_cv = cv_cnt;
    sb.push_back({4'h5, 16'h0102});
    send5(8'hA5, 8'h05, 8'h01, 8'h02, 8'h06);
    drain();
    chk("tmo_next_cv", 32'(cv_cnt - base_cv), 1);

    // Address out of range
    do_reset(1'b0);
    base_cv = cv_cnt; base_fe = fe_cnt;
    send_byte(8'hA5);
    send_byte(8'hF0);
    repeat (4) @(posedge Clk);
    chk("badaddr_fe", 32'(fe_cnt - base_fe), 1);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hC6);
    repeat (5) @(posedge Clk);
    chk("badaddr_no_cv", 32'(cv_cnt - base_cv), 0);

    // Reset mid-frame and in ISSUE discards, next frame decodes
    do_reset(1'b0);
    base_cv = cv_cnt;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h12);
    do_reset(1'b0);
    C_Rdy = 1'b0;
    send5(8'hA5, 8'h01, 8'h12, 8'h34, 8'h27);
    do_reset(1'b0);
    C_Rdy = 1'b1;
    repeat (5) @(posedge Clk);
    chk("rst_discard_cv", 32'(cv_cnt - base_cv), 0);
    sb.push_back({4'h7, 16'h00FF});
    send5(8'hA5, 8'h07, 8'h00, 8'hFF, 8'hF8);
    drain();
    chk("rst_next_cv", 32'(cv_cnt - base_cv), 1);

    // Error counter saturation
    base_fe = fe_cnt;
    for (int i = 0; i < 300; i++) begin
      send5(8'hA5, 8'h01, 8'h12, 8'h34, 8'h00);
      if (i == 254) begin
        @(negedge Clk);
        chk("sat_at_255", 32'(Err_Count), 255);
      end
    end
    repeat (4) @(posedge Clk);
    chk("sat_fe_count", 32'(fe_cnt - base_fe), 300);
    chk("sat_err_count", 32'(Err_Count), 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
